// File: rtl/hv_abist_seq.sv
// HV analog BIST sequencer: walks the six HV BIST items in fixed order, holds each
// enable for its detection window, samples the checker status and accumulates pass/fail.
module hv_abist_seq #(
   parameter int unsigned CLK_M      = 48,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic [5:0] i_item_en,
   input  logic [5:0] i_bist_status,
   output logic [5:0] o_bist_req,
   output logic       o_busy,
   output logic       o_done,
   output logic [5:0] o_pass,
   output logic       o_fail,
   output logic [2:0] o_cur_item
);

   localparam int unsigned ITEM_NUM  = 6;
   localparam int unsigned CNT_W     = $clog2(70 * CLK_M + SETTLE_CYC + 2);
   localparam logic [2:0]  LAST_ITEM = 3'(ITEM_NUM - 1);

   typedef enum logic [2:0] {StIdle, StSettle, StRun, StSample, StDone} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            k_q, k_d;
   logic [ITEM_NUM-1:0]   mask_q, mask_d;
   logic [ITEM_NUM-1:0]   pass_q, pass_d;
   logic [CNT_W-1:0]      window;
   logic                  item_active;

   always_comb begin
      case (k_q)
         3'd0:    window = CNT_W'(70 * CLK_M);
         3'd5:    window = CNT_W'(4 * CLK_M);
         default: window = CNT_W'(CLK_M);
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      mask_d  = mask_q;
      pass_d  = pass_q;
      if (i_abort) begin
         // Abort wins over everything, including a simultaneous start; partial results stay.
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (i_start) begin
                  mask_d  = i_item_en;
                  pass_d  = '1;
                  k_d     = 3'd0;
                  cnt_d   = '0;
                  state_d = StSettle;
               end
            end
            StSettle: begin
               if (!mask_q[k_q]) begin
                  cnt_d = '0;
                  if (k_q == LAST_ITEM) state_d = StDone;
                  else                  k_d     = k_q + 3'd1;
               end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                  // First RUN cycle counts as 1.
                  cnt_d   = CNT_W'(1);
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StRun: begin
               if (cnt_q == window) begin
                  cnt_d   = '0;
                  state_d = StSample;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StSample: begin
               pass_d[k_q] = i_bist_status[k_q];
               cnt_d       = '0;
               if (k_q == LAST_ITEM) begin
                  state_d = StDone;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = StSettle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         k_q     <= 3'd0;
         mask_q  <= '0;
         pass_q  <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         mask_q  <= mask_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      item_active = (state_q == StRun) || (state_q == StSample);
      o_bist_req  = item_active ? (ITEM_NUM'(1) << k_q) : '0;
      o_cur_item  = item_active ? k_q : 3'd7;
      o_busy      = item_active || (state_q == StSettle);
      o_done      = (state_q == StDone);
      o_pass      = pass_q;
      o_fail      = o_done && !(&pass_q);
   end

endmodule

// File: tb/tb_hv_abist_seq.sv
// Directed bench for hv_abist_seq: table of full sequences plus hand-written abort,
// busy-start, restart-from-done and asynchronous-reset cases.
module tb_hv_abist_seq;

   localparam int W0 = 3361;   // ov request high time: 70*48+1
   localparam int W1 = 49;     // ot/opscod/oc/sc: 48+1
   localparam int W5 = 193;    // adc: 4*48+1
   localparam int BUDGET = 20000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [5:0] item_en = '0;
   logic [5:0] status = '0;
   logic [5:0] req;
   logic       busy, done, fail;
   logic [5:0] pass;
   logic [2:0] cur;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hv_abist_seq #(.CLK_M(48), .SETTLE_CYC(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_abort      (abort),
      .i_item_en    (item_en),
      .i_bist_status(status),
      .o_bist_req   (req),
      .o_busy       (busy),
      .o_done       (done),
      .o_pass       (pass),
      .o_fail       (fail),
      .o_cur_item   (cur)
   );

   function automatic int idx_of(input logic [5:0] v);
      for (int i = 0; i < 6; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Request monitor: per-bit high time, low gap before each rise, one-hot/order/cur_item checks.
   int         seq_id = 0;
   int         mon_seq = 0;
   int         len [6];
   int         gap [6];
   int         zero_run, last_idx, onehot_err, cur_err, order_err;
   logic [5:0] prev_req;

   always @(negedge clk) begin
      if (mon_seq != seq_id) begin
         mon_seq <= seq_id;
         for (int i = 0; i < 6; i++) begin
            len[i] <= 0;
            gap[i] <= 0;
         end
         zero_run   <= 0;
         last_idx   <= -1;
         onehot_err <= 0;
         cur_err    <= 0;
         order_err  <= 0;
         prev_req   <= '0;
      end else begin
         if (req == '0) begin
            zero_run <= zero_run + 1;
            if (cur != 3'd7) cur_err <= cur_err + 1;
         end else begin
            zero_run <= 0;
            if (!$onehot(req)) begin
               onehot_err <= onehot_err + 1;
            end else begin
               if (32'(cur) != idx_of(req)) cur_err <= cur_err + 1;
               if (req != prev_req) begin
                  gap[idx_of(req)] <= zero_run;
                  if (idx_of(req) <= last_idx) order_err <= order_err + 1;
                  last_idx <= idx_of(req);
               end
               len[idx_of(req)] <= len[idx_of(req)] + 1;
            end
         end
         prev_req <= req;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic start_seq(input logic [5:0] mask, input logic [5:0] st);
      @(negedge clk);
      seq_id  = seq_id + 1;
      item_en = mask;
      status  = st;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges until o_done is seen; a timeout is a failed comparison.
   task automatic wait_done(input string name, output int lat);
      lat = 0;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         lat++;
         if (done) return;
      end
      check({name, " done timeout"}, 32'(done), 32'd1);
   endtask

   // Returns at the n-th negedge with o_cur_item == item.
   task automatic wait_cur(input string name, input logic [2:0] item, input int nth);
      int seen = 0;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (cur == item) seen++;
         if (seen == nth) return;
      end
      check({name, " cur_item timeout"}, 32'(cur), 32'(item));
   endtask

   typedef struct packed {
      logic [5:0]        mask;
      logic [5:0]        status;
      logic [5:0]        exp_pass;
      logic              exp_fail;
      logic [31:0]       exp_lat;
      logic [5:0][11:0]  exp_len;
      logic [5:0][11:0]  exp_gap;   // 0 = not checked
   } vec_t;

   vec_t vecs [7];

   initial begin
      int lat, n;
      string nm;

      vecs[0] = '{6'h3F, 6'h3F, 6'h3F, 1'b0, 3799, {12'(W5), 12'(W1), 12'(W1), 12'(W1), 12'(W1), 12'(W0)},
                  {12'd8, 12'd8, 12'd8, 12'd8, 12'd8, 12'd0}};
      vecs[1] = '{6'h3F, 6'h37, 6'h37, 1'b1, 3799, {12'(W5), 12'(W1), 12'(W1), 12'(W1), 12'(W1), 12'(W0)},
                  {12'd8, 12'd8, 12'd8, 12'd8, 12'd8, 12'd0}};
      vecs[2] = '{6'h21, 6'h3F, 6'h3F, 1'b0, 3575, {12'(W5), 12'd0, 12'd0, 12'd0, 12'd0, 12'(W0)},
                  {12'd12, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
      vecs[3] = '{6'h00, 6'h3F, 6'h3F, 1'b0, 7, '0, '0};
      vecs[4] = '{6'h3F, 6'h00, 6'h00, 1'b1, 3799, {12'(W5), 12'(W1), 12'(W1), 12'(W1), 12'(W1), 12'(W0)},
                  {12'd8, 12'd8, 12'd8, 12'd8, 12'd8, 12'd0}};
      vecs[5] = '{6'h12, 6'h2D, 6'h2D, 1'b1, 119, {12'd0, 12'(W1), 12'd0, 12'd0, 12'(W1), 12'd0},
                  {12'd0, 12'd10, 12'd0, 12'd0, 12'd0, 12'd0}};
      vecs[6] = '{6'h1E, 6'h20, 6'h21, 1'b1, 231, {12'd0, 12'(W1), 12'(W1), 12'(W1), 12'(W1), 12'd0},
                  {12'd0, 12'd8, 12'd8, 12'd8, 12'd0, 12'd0}};

      // Reset state
      #12;
      check("rst req", 32'(req), 32'h0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst pass", 32'(pass), 32'h3F);
      check("rst fail", 32'(fail), 32'd0);
      check("rst cur_item", 32'(cur), 32'd7);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         start_seq(vecs[v].mask, vecs[v].status);
         check($sformatf("v%0d busy after start", v), 32'(busy), 32'd1);
         wait_done($sformatf("v%0d", v), lat);
         #2;
         check($sformatf("v%0d latency", v), 32'(lat), vecs[v].exp_lat);
         check($sformatf("v%0d pass", v), 32'(pass), 32'(vecs[v].exp_pass));
         check($sformatf("v%0d fail", v), 32'(fail), 32'(vecs[v].exp_fail));
         check($sformatf("v%0d busy in done", v), 32'(busy), 32'd0);
         check($sformatf("v%0d req in done", v), 32'(req), 32'h0);
         check($sformatf("v%0d cur_item in done", v), 32'(cur), 32'd7);
         for (int b = 0; b < 6; b++) begin
            check($sformatf("v%0d req%0d high time", v, b), 32'(len[b]), 32'(vecs[v].exp_len[b]));
            if (vecs[v].exp_gap[b] != 0)
               check($sformatf("v%0d gap before req%0d", v, b), 32'(gap[b]), 32'(vecs[v].exp_gap[b]));
         end
         check($sformatf("v%0d onehot errors", v), 32'(onehot_err), 32'd0);
         check($sformatf("v%0d cur_item errors", v), 32'(cur_err), 32'd0);
         check($sformatf("v%0d order errors", v), 32'(order_err), 32'd0);
      end

      // Abort at cycle 100 of the ov window, then restart from item 0
      start_seq(6'h3F, 6'h3F);
      n = 0;
      for (int i = 0; i < BUDGET && n < 100; i++) begin
         @(negedge clk);
         if (req[0]) n++;
      end
      check("abort reached ov cycle 100", 32'(n), 32'd100);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort req", 32'(req), 32'h0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort cur_item", 32'(cur), 32'd7);
      check("abort pass", 32'(pass), 32'h3F);
      repeat (3) @(negedge clk);
      check("abort stays idle", 32'(busy), 32'd0);
      start_seq(6'h3F, 6'h3F);
      wait_done("restart", lat);
      #2;
      check("restart latency", 32'(lat), 32'd3799);
      check("restart req0 high time", 32'(len[0]), 32'(W0));
      check("restart pass", 32'(pass), 32'h3F);

      // Abort keeps partial results: ov failed, abort during ot
      start_seq(6'h03, 6'h3E);
      wait_cur("partial", 3'd1, 5);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("partial pass", 32'(pass), 32'h3E);
      check("partial fail", 32'(fail), 32'd0);
      check("partial done", 32'(done), 32'd0);

      // Second start during oc RUN is ignored
      start_seq(6'h3F, 6'h3F);
      n = 0;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         n++;
         if (req[3] && len[3] == 19) break;
      end
      item_en = 6'h00;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      item_en = 6'h3F;
      wait_done("busy start", lat);
      #2;
      check("busy start latency", 32'(n + lat), 32'd3799);
      check("busy start req3 high time", 32'(len[3]), 32'(W1));
      check("busy start req5 high time", 32'(len[5]), 32'(W5));
      check("busy start pass", 32'(pass), 32'h3F);

      // Start from DONE clears done and begins a new sequence
      start_seq(6'h01, 6'h00);
      check("done restart done", 32'(done), 32'd0);
      check("done restart busy", 32'(busy), 32'd1);
      check("done restart pass reset", 32'(pass), 32'h3F);
      wait_done("done restart", lat);
      #2;
      check("done restart latency", 32'(lat), 32'd3375);
      check("done restart pass", 32'(pass), 32'h3E);
      check("done restart fail", 32'(fail), 32'd1);

      // Start together with abort in DONE: abort wins
      @(negedge clk);
      item_en = 6'h3F;
      start   = 1'b1;
      abort   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      abort = 1'b0;
      check("start+abort busy", 32'(busy), 32'd0);
      check("start+abort done", 32'(done), 32'd0);
      check("start+abort pass held", 32'(pass), 32'h3E);

      // Asynchronous reset mid-sequence
      start_seq(6'h3F, 6'h3E);
      wait_cur("async rst", 3'd1, 10);
      #2 rst_n = 1'b0;
      #1;
      check("async rst req", 32'(req), 32'h0);
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst pass", 32'(pass), 32'h3F);
      check("async rst cur_item", 32'(cur), 32'd7);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("after rst idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hv_abist_seq.md
Name: hv_abist_seq

Overview:
- Sequencer for the HV analog built-in self-test.
- On a start request, drives the six HV BIST item enables one at a time, in fixed order: ov, ot, opscod, oc, sc, adc.
- Holds each enable for that item's detection window, then samples the per-item status returned by the HV BIST checker.
- Accumulates a pass/fail vector and raises a done flag. It sits between the LV-side BIST control register interface and the HV BIST checker.

Parameters:
- CLK_M, 48, clock cycles per microsecond.
- SETTLE_CYC, 8, idle cycles between items; all enables are low during this time.
- ITEM_NUM, 6, number of BIST items. Fixed: bit0 ov, bit1 ot, bit2 opscod, bit3 oc, bit4 sc, bit5 adc.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_start  in  1  single-cycle start pulse. Ignored unless the FSM is in IDLE or DONE.
- i_abort  in  1  level. Aborts the sequence and returns to IDLE.
- i_item_en  in  6  per-item enable mask. Sampled on an accepted i_start.
- i_bist_status  in  6  per-item status from the checker; 1 = detected.
- o_bist_req  out  6  one-hot item enable to the checker.
- o_busy  out  1  high from the cycle after an accepted start until DONE or IDLE is entered.
- o_done  out  1  high in DONE state.
- o_pass  out  6  per-item result: 1 = pass. Bits for skipped items read 1.
- o_fail  out  1  OR of ~o_pass, valid while o_done is high.
- o_cur_item  out  3  index of the item being run; 7 when no item is active.

Interface (already decided):
- Reset i_rst_n, asynchronous, active-low; clock i_clk.

Behaviour:
- Reset values: o_bist_req=0, o_busy=0, o_done=0, o_pass=6'h3F, o_fail=0, o_cur_item=7. The FSM resets to IDLE and all counters clear.
- Item windows, in cycles: ov 70*CLK_M, ot/opscod/oc/sc 1*CLK_M each, adc 4*CLK_M.
- Counter width is $clog2(70*CLK_M+SETTLE_CYC+2).
- FSM states: IDLE, SETTLE, RUN, SAMPLE, DONE.
- IDLE/DONE on i_start with i_abort low:
  - latch i_item_en into mask_q;
  - set o_pass=6'h3F and clear o_done;
  - set item index k=0 and go to SETTLE.
- If i_start and i_abort are high together, abort wins: go to IDLE.
- SETTLE:
  - if mask_q[k]=0, mark the item skipped (o_pass[k] stays 1) and advance k in the next cycle without entering RUN;
  - otherwise count SETTLE_CYC cycles, then go to RUN.
- RUN:
  - o_bist_req[k]=1 and o_cur_item=k;
  - count exactly window[k] cycles, with the first RUN cycle counting as 1;
  - then go to SAMPLE.
- SAMPLE (1 cycle):
  - o_bist_req stays high;
  - o_pass[k] <= i_bist_status[k];
  - if k==5, go to DONE; otherwise k++ and go to SETTLE.
- o_bist_req drops in the cycle after SAMPLE. Total request high time per enabled item = window[k]+1 cycles.
- DONE: o_done=1, o_busy=0, o_bist_req=0. o_pass and o_fail hold until the next accepted start or reset.
- i_abort in any state (sampled synchronously):
  - next cycle: o_bist_req=0, o_busy=0, o_done=0, o_cur_item=7;
  - o_pass keeps the partial results;
  - FSM goes to IDLE.
- i_start while busy (SETTLE/RUN/SAMPLE) is ignored, with no effect on counters.
- All-zero mask: walk through six SETTLE skip cycles, then DONE with o_pass=6'h3F and o_fail=0.
- o_bist_req is always one-hot or zero; never two bits high at once.
- i_bist_status bits outside SAMPLE are ignored.
- Asynchronous reset mid-sequence returns all outputs to reset values immediately.

Test Plan:
- Mask=6'h3F, checker status=6'h3F: req bit0 high for 70*48+1=3361 cycles, bits1-4 high for 49 cycles each, bit5 high for 193 cycles, 8-cycle gaps between items -> o_done=1, o_pass=6'h3F, o_fail=0.
- Mask=6'h3F, status bit3 forced 0 -> o_pass=6'h37, o_fail=1, other items run normally.
- Mask=6'h21 -> only req bit0 then bit5 assert, o_cur_item shows 0 then 5, o_pass bits1-4 read 1.
- i_abort pulsed at cycle 100 of the ov RUN -> next cycle o_bist_req=0, o_busy=0, FSM in IDLE; a new i_start then restarts from item 0.
- Second i_start during oc RUN -> sequence and counters unchanged; i_start in DONE -> o_done clears, new sequence begins.
- Mask=0 -> o_done asserts after 6 skip cycles plus 1, o_bist_req never asserts, o_fail=0.
